adder_4bit_seq: RTL and testbench

- Multi-cycle add/subtract sequencer for WIDTH-bit operands built on one shared adder_4bit instance.
- Processes one nibble per cycle, LSB first, with a registered carry chained between cycles.
- Valid/ready handshake on both input and output.
- Sits between a requester (ALU/control FSM) and the nibble adder datapath, so wide arithmetic needs only one 4-bit adder.

---
 rtl/adder_4bit_seq_pkg.sv | 17 +
 rtl/adder_4bit.sv | 16 +
 rtl/adder_4bit_seq.sv | 116 +++++++++++
 tb/tb_adder_4bit_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_4bit_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
`default_nettype none

package adder_4bit_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/adder_4bit.sv
// Combinational 4-bit adder with carry in and carry out.
`default_nettype none

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

`default_nettype wire

// File: rtl/adder_4bit_seq.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared 4-bit adder,
// one nibble per cycle LSB first, with valid/ready on both sides.
`default_nettype none

module adder_4bit_seq
  import adder_4bit_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [IDXW+1:0]  bit_base;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  assign bit_base = {idx, 2'b00};
  assign nib_a    = a_r[bit_base +: 4];
  assign nib_b    = b_r[bit_base +: 4];

  adder_4bit u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1; the +1 enters as carry into nibble 0.
            a_r      <= a;
            b_r      <= (op_sub == OP_SUB) ? ~b : b;
            carry    <= op_sub;
            idx      <= '0;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_RUN: begin
          sum[bit_base +: 4] <= nib_sum;
          carry              <= nib_cout;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            cout      <= nib_cout;
            ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nib_sum[3] != a_r[WIDTH-1]);
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_4bit_seq.sv
// Self-checking bench for adder_4bit_seq (WIDTH=16 plus a WIDTH=4 instance).
`default_nettype none

module tb_adder_4bit_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf, busy;
  logic [15:0] sum;

  logic        in_valid4 = 1'b0, op_sub4 = 1'b0, out_ready4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, cout4, ovf4, busy4;
  logic [3:0]  sum4;

  adder_4bit_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .busy(busy)
  );

  adder_4bit_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op_sub(op_sub4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
    .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {cout, ovf, sum}.
  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic sub);
    logic [16:0] full;
    logic [15:0] r;
    logic        c, o;
    if (sub) begin
      r = x - y;
      c = (x >= y);
      o = (x[15] != y[15]) && (r[15] != x[15]);
    end else begin
      full = {1'b0, x} + {1'b0, y};
      r = full[15:0];
      c = full[16];
      o = (x[15] == y[15]) && (r[15] != x[15]);
    end
    return {c, o, r};
  endfunction

  task automatic run16(input string name, input logic [15:0] x, input logic [15:0] y,
                       input logic sub, input logic [15:0] es, input logic ec, input logic eo);
    int edges;
    @(negedge clk);
    check({name, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1; a = x; b = y; op_sub = sub;
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      check({name, " in_ready/busy run"}, {in_ready, busy}, 2'b01);
      @(negedge clk);
      edges++;
    end
    check({name, " latency"}, edges, 4);
    check({name, " sum"}, sum, es);
    check({name, " cout"}, cout, ec);
    check({name, " ovf"}, ovf, eo);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid drop"}, out_valid, 0);
    check({name, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] m;
    logic [15:0] rx, ry;
    logic        rs;
    int          edges, nres;

    vecs[0] = '{"add 1234+0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{"add ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add 7fff+0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"sub 0005-0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub 8000-0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{"sub 0000-0000", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{"add 8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset sum", sum, 0);
    check("reset cout/ovf", {cout, ovf}, 0);
    check("reset dut4 in_ready", in_ready4, 1);
    rst = 1'b0;

    foreach (vecs[i])
      run16(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].o);

    for (int i = 0; i < 30; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i < 4) ry = 16'hFFFF - 16'(i);
      m = model16(rx, ry, rs);
      run16($sformatf("rand%0d %h%s%h", i, rx, rs ? "-" : "+", ry), rx, ry, rs, m[15:0], m[17], m[16]);
    end

    // Backpressure with ignored requests during RUN and DONE
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h0FFF; op_sub = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b1;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
      in_valid = ~in_valid;
      a = a + 16'h0101;
    end
    check("bp latency", edges, 4);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 16'(k * 7 + 3); b = 16'h5555;
      @(negedge clk);
      check("bp out_valid held", out_valid, 1);
      check("bp sum held", sum, 16'h2233);
      check("bp cout/ovf held", {cout, ovf}, 2'b00);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp return idle", {in_ready, out_valid, busy}, 3'b100);
    check("bp sum kept in idle", sum, 16'h2233);

    // Reset during the second RUN cycle
    @(negedge clk);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; op_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun rst in_ready", in_ready, 1);
    check("midrun rst out_valid/busy", {out_valid, busy}, 2'b00);
    check("midrun rst sum", sum, 0);
    rst = 1'b0;
    run16("after rst 1+1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; op_sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; op_sub = 1'b1;
    nres = 0;
    for (int e = 1; e <= 20 && nres < 2; e++) begin
      @(negedge clk);
      if (out_valid) begin
        if (nres == 0) begin
          check("b2b first edge", e, 4);
          check("b2b first sum", sum, 16'h3333);
        end else begin
          check("b2b second edge", e, 10);
          check("b2b second sum", sum, 16'hFFF0);
          check("b2b second cout/ovf", {cout, ovf}, 2'b00);
          in_valid = 1'b0;
        end
        nres++;
      end
    end
    check("b2b results seen", nres, 2);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // WIDTH=4 instance: single RUN cycle
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'h1; op_sub4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    edges = 0;
    while (!out_valid4 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("w4 latency", edges, 1);
    check("w4 F+1 sum", sum4, 4'h0);
    check("w4 F+1 cout/ovf", {cout4, ovf4}, 2'b10);
    out_ready4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'h7; b4 = 4'h1; op_sub4 = 1'b0;
    out_ready4 = 1'b0;
    check("w4 back idle", in_ready4, 1);
    @(negedge clk);
    in_valid4 = 1'b0;
    edges = 0;
    while (!out_valid4 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("w4 7+1 sum", sum4, 4'h8);
    check("w4 7+1 cout/ovf", {cout4, ovf4}, 2'b01);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
